mac_seq: RTL
============

// Module: mac_seq
// PURPOSE
//  Sequencer/initiator that drives the pipelined MAC (valid_input/clear_acc side) to compute y = W*x.
//  - Reads W (M x K, row-major) and x (K) from external 1-cycle-latency sync RAMs.
//  - Streams operand pairs into the MAC, waits out the MAC pipeline, then captures each row result.
//  - Returns each row result on a valid/ready output port.
// PARAMETERS
//  INW   16  operand width (signed)
//  OUTW  48  accumulator/result width (signed); must equal the MAC OUTW
//  K     8   vector length (MACs per row), >=1
//  M     4   number of rows (results per job), >=1
// PORTS
//  clk         in   1                 clock; all state on posedge
//  reset_n     in   1                 asynchronous, active-low reset
//  start       in   1                 job request; sampled only in IDLE
//  busy        out  1                 high from accepted start until last result handshakes
//  w_addr      out  $clog2(M*K)       W RAM read address = row*K + col
//  x_addr      out  $clog2(K)         x RAM read address = col
//  rd_en       out  1                 RAM read enable; data returns the next cycle
//  w_data      in   INW               W RAM read data
//  x_data      in   INW               x RAM read data
//  mac_in0     out  INW               = w_data (pass-through)
//  mac_in1     out  INW               = x_data (pass-through)
//  mac_valid   out  1                 rd_en delayed one cycle
//  mac_clear   out  1                 MAC accumulator clear
//  mac_out     in   OUTW              MAC accumulator value
//  out_data    out  OUTW              row result; held stable while out_valid && !out_ready
//  out_valid   out  1                 result available
//  out_ready   in   1                 consumer accepts; transfer = out_valid && out_ready
// BEHAVIOUR
//  Reset:
//   - Async reset drives state=IDLE, row=col=0, busy=0, rd_en=0, mac_valid=0, out_valid=0, out_data=0.
//   - mac_clear=1 during reset and throughout IDLE, which holds the MAC at 0.
//  FSM states: IDLE -> READ -> DRAIN -> OUT -> (READ | IDLE)
//   - IDLE:  start=1 -> READ, with row=0, col=0, busy=1. mac_clear deasserts on entry to READ.
//   - READ:  rd_en=1 for exactly K cycles, col 0..K-1. Last col -> DRAIN with col=0.
//   - DRAIN: exactly MAC_LAT=2 cycles, rd_en=0. This covers the MAC product register plus accumulate.
//   - OUT:   out_valid=1, out_data=mac_out. mac_out is stable because mac_valid=0 feeds zeros into the MAC.
//     - On handshake with row<M-1: mac_clear=1 for that cycle, row++, next state READ.
//     - On handshake with row=M-1: next state IDLE, busy=0.
//  Latency:
//   - Start sampled at edge 0: reads in cycles 1..K; first out_valid in cycle K+3.
//   - Each subsequent row result appears K+3 cycles after the previous handshake.
//  Back-pressure:
//   - out_ready low holds OUT indefinitely; out_data does not change.
//   - out_valid never drops without a handshake.
//  Row boundary:
//   - Clear and the next row's first read are issued in the same cycle.
//   - The first product reaches the accumulator 2 edges later, so no product is lost.
//   - Rows never overlap in the MAC.
//  Boundary conditions:
//   - start while busy: ignored. start high continuously: a new job begins the cycle after returning to IDLE.
//   - Arithmetic: no arithmetic in this block; saturation is owned by the MAC. out_data = mac_out bit-exact.
//   - reset_n low mid-job: job abandoned immediately; all outputs return to reset values. No partial result is emitted.
// CONFIGURATION
//  MAC_SEQ_PERF_EN
//   - Defined: adds output perf_cycles [31:0]. Cleared on accepted start; increments every busy cycle;
//     holds its value in IDLE; saturates at 2^32-1.
//   - Undefined: port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  mac_seq_pkg:
//   - state_t enum (IDLE, READ, DRAIN, OUT).
//   - Constants MEM_LAT=1, MAC_LAT=2.
//   - Function for address widths.
//  Sub-module mac_seq_addr_gen: row/col counters, w_addr/x_addr generation, last_col/last_row flags.
//  FSM, MAC-side signals and output register stay in mac_seq.
// TESTING (K=4, M=2, INW=16, OUTW=48, mac_seq connected to the real MAC and RAM models)
//  1. Basic job
//     - W={1,2,3,4; -1,-1,-1,-1}, x={5,6,7,8}, out_ready=1.
//     - Expect out_data 70 then -26. First out_valid at cycle 7 after start. busy drops after the 2nd handshake.
//  2. Back-pressure
//     - Same data, out_ready=0 for 10 cycles at OUT.
//     - Expect out_valid held, out_data=70 stable, then 70 and -26 delivered exactly once each.
//  3. Saturation pass-through
//     - W row0 all 32767, x all 32767, OUTW=32.
//     - Expect 2147483647 (MAC saturates). Row1 result is correct, which proves the clear took effect.
//  4. Start handling
//     - Pulse start mid-job: ignored, exactly 2 results.
//     - start held high: back-to-back jobs, 4 results, IDLE for 1 cycle between jobs.
//  5. Reset mid-job
//     - Assert reset_n low during READ of row1.
//     - Expect all outputs 0 asynchronously. The next job returns 70, -26 (no stale accumulation).
//  6. MAC_SEQ_PERF_EN defined
//     - Run test 1 with out_ready=1.
//     - Expect perf_cycles = 2*(K+3)+1 = 15 in IDLE afterwards.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared FSM state type, pipeline latencies and address-width helper for mac_seq
package mac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int MEM_LAT = 1;
    localparam int MAC_LAT = 2;

    // Counter/address width for n entries, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_seq_addr_gen.sv
// rtl/mac_seq_addr_gen.sv - row/col counters and W/x RAM address generation for mac_seq
module mac_seq_addr_gen
    import mac_seq_pkg::*;
#(
    parameter int K = 8,
    parameter int M = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   job_start,
    input  logic                   col_inc,
    input  logic                   row_inc,
    output logic [addr_w(M*K)-1:0] w_addr,
    output logic [addr_w(K)-1:0]   x_addr,
    output logic                   last_col,
    output logic                   last_row
);

    localparam int CW = addr_w(K);
    localparam int RW = addr_w(M);
    localparam int AW = addr_w(M*K);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    assign last_col = (col == CW'(K-1));
    assign last_row = (row == RW'(M-1));
    assign x_addr   = col;
    assign w_addr   = AW'(int'(row) * K + int'(col));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (job_start) begin
            col <= '0;
            row <= '0;
        end else begin
            // col wraps so the next row starts at column 0
            if (col_inc) col <= last_col ? '0 : col + CW'(1);
            if (row_inc) row <= row + RW'(1);
        end
    end

endmodule

// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - sequencer feeding W/x operand pairs into a pipelined MAC and returning y = W*x row results
// Optional feature: MAC_SEQ_PERF_EN adds the perf_cycles busy-cycle counter output.
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int INW  = 16,
    parameter int OUTW = 48,
    parameter int K    = 8,
    parameter int M    = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   busy,
    output logic [addr_w(M*K)-1:0] w_addr,
    output logic [addr_w(K)-1:0]   x_addr,
    output logic                   rd_en,
    input  logic signed [INW-1:0]  w_data,
    input  logic signed [INW-1:0]  x_data,
    output logic signed [INW-1:0]  mac_in0,
    output logic signed [INW-1:0]  mac_in1,
    output logic                   mac_valid,
    output logic                   mac_clear,
    input  logic signed [OUTW-1:0] mac_out,
    output logic signed [OUTW-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef MAC_SEQ_PERF_EN
    ,
    output logic [31:0]            perf_cycles
`endif
);

    localparam int DW = $clog2(MAC_LAT + 1);

    state_t             state, state_n;
    logic [DW-1:0]      drain_cnt;
    logic [MEM_LAT-1:0] rd_pipe;
    logic               job_start, handshake, last_col, last_row;

    assign job_start = (state == IDLE) && start;
    assign handshake = out_valid && out_ready;

    mac_seq_addr_gen #(
        .K (K),
        .M (M)
    ) u_addr_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .job_start (job_start),
        .col_inc   (rd_en),
        .row_inc   (handshake && !last_row),
        .w_addr    (w_addr),
        .x_addr    (x_addr),
        .last_col  (last_col),
        .last_row  (last_row)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            drain_cnt <= '0;
            rd_pipe   <= '0;
        end else begin
            state     <= state_n;
            drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
            rd_pipe   <= MEM_LAT'({rd_pipe, rd_en});
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = READ;
            READ:    if (last_col) state_n = DRAIN;
            DRAIN:   if (drain_cnt == DW'(MAC_LAT - 1)) state_n = OUT;
            OUT:     if (out_ready) state_n = last_row ? IDLE : READ;
            default: state_n = IDLE;
        endcase
    end

    // mac_valid=0 outside READ feeds zeros, so mac_out is frozen while OUT waits on out_ready
    always_comb begin
        busy      = (state != IDLE);
        rd_en     = (state == READ);
        out_valid = (state == OUT);
        out_data  = out_valid ? mac_out : '0;
        mac_clear = (state == IDLE) || (handshake && !last_row);
        mac_valid = rd_pipe[MEM_LAT-1];
        mac_in0   = w_data;
        mac_in1   = x_data;
    end

`ifdef MAC_SEQ_PERF_EN
    // The accepting cycle is counted, hence the load of 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            perf_cycles <= '0;
        else if (job_start)
            perf_cycles <= 32'd1;
        else if (busy && (perf_cycles != 32'hFFFF_FFFF))
            perf_cycles <= perf_cycles + 32'd1;
    end
`endif

endmodule
